// File: rtl/decode_ctrl.sv
// Instruction-field decoder with a valid/ready handshake on both sides.
// MUL results are held back for MUL_CYCLES cycles before being offered downstream.
module decode_ctrl #(
    parameter int ALU_CTRL_W = 4,
    parameter int MUL_CYCLES = 3,
    parameter int EN_ITYPE   = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic [6:0]            funct7,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  regwrite_control,
    output logic                  alusrc_imm,
    output logic                  illegal,
    output logic                  busy
);

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_MUL = 4'b0110;
    localparam logic [3:0] ALU_XOR = 4'b0111;

    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_WAIT = 2'd1,
        OUT      = 2'd2
    } state_t;

    state_t                  state_q;
    logic [3:0]              cnt_q;
    logic                    out_valid_q;
    logic                    busy_q;
    logic [ALU_CTRL_W-1:0]   alu_q;
    logic                    regw_q;
    logic                    imm_q;
    logic                    ill_q;

    logic [3:0]              dec_alu_d;
    logic                    dec_legal_d;
    logic                    dec_imm_d;
    logic                    dec_mul_d;
    logic                    accept;

    always_comb begin
        dec_alu_d   = ALU_ADD;
        dec_legal_d = 1'b0;
        dec_imm_d   = 1'b0;
        dec_mul_d   = 1'b0;
        if (opcode == OP_R) begin
            case ({funct7, funct3})
                {7'b0000000, 3'd0}: begin dec_alu_d = ALU_ADD; dec_legal_d = 1'b1; end
                {7'b0100000, 3'd0}: begin dec_alu_d = ALU_SUB; dec_legal_d = 1'b1; end
                {7'b0000000, 3'd6}: begin dec_alu_d = ALU_OR;  dec_legal_d = 1'b1; end
                {7'b0000000, 3'd7}: begin dec_alu_d = ALU_AND; dec_legal_d = 1'b1; end
                {7'b0000000, 3'd1}: begin dec_alu_d = ALU_SLL; dec_legal_d = 1'b1; end
                {7'b0000000, 3'd5}: begin dec_alu_d = ALU_SRL; dec_legal_d = 1'b1; end
                {7'b0000000, 3'd4}: begin dec_alu_d = ALU_XOR; dec_legal_d = 1'b1; end
                {7'b0000001, 3'd2}: begin
                    dec_alu_d   = ALU_MUL;
                    dec_legal_d = 1'b1;
                    dec_mul_d   = 1'b1;
                end
                default: ;
            endcase
        end else if (opcode == OP_I && EN_ITYPE != 0) begin
            // Immediate shifts share funct7 with the shamt field's upper bits; only f7=0 is legal.
            case (funct3)
                3'd0: begin dec_alu_d = ALU_ADD; dec_legal_d = 1'b1; end
                3'd6: begin dec_alu_d = ALU_OR;  dec_legal_d = 1'b1; end
                3'd7: begin dec_alu_d = ALU_AND; dec_legal_d = 1'b1; end
                3'd4: begin dec_alu_d = ALU_XOR; dec_legal_d = 1'b1; end
                3'd1: begin dec_alu_d = ALU_SLL; dec_legal_d = (funct7 == 7'd0); end
                3'd5: begin dec_alu_d = ALU_SRL; dec_legal_d = (funct7 == 7'd0); end
                default: ;
            endcase
            dec_imm_d = dec_legal_d;
        end
        if (!dec_legal_d) begin
            dec_alu_d = ALU_ADD;
        end
    end

    assign in_ready = (state_q == IDLE) || (state_q == OUT && out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            alu_q       <= '0;
            regw_q      <= 1'b0;
            imm_q       <= 1'b0;
            ill_q       <= 1'b0;
        end else begin
            case (state_q)
                MUL_WAIT: begin
                    if (cnt_q == 4'd1) begin
                        state_q     <= OUT;
                        cnt_q       <= 4'd0;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    if (accept) begin
                        alu_q  <= ALU_CTRL_W'(dec_alu_d);
                        regw_q <= dec_legal_d;
                        imm_q  <= dec_imm_d;
                        ill_q  <= !dec_legal_d;
                        if (dec_mul_d && MUL_CYCLES > 1) begin
                            state_q     <= MUL_WAIT;
                            cnt_q       <= MUL_LOAD;
                            out_valid_q <= 1'b0;
                            busy_q      <= 1'b1;
                        end else begin
                            state_q     <= OUT;
                            out_valid_q <= 1'b1;
                            busy_q      <= 1'b0;
                        end
                    end else if (state_q == OUT && out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign out_valid        = out_valid_q;
    assign busy             = busy_q;
    assign alu_control      = alu_q;
    assign regwrite_control = regw_q;
    assign alusrc_imm       = imm_q;
    assign illegal          = ill_q;

endmodule

// File: tb/tb_decode_ctrl.sv
// Randomized bench for decode_ctrl: two parameterizations driven concurrently,
// each checked cycle by cycle against a transaction-level reference model.
module tb_decode_ctrl;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int edges = 0;
    always @(posedge clock) edges <= edges + 1;

    logic [1:0] rst, iv, ordy;
    logic [1:0] ir, ov, bsy, regw, asrc, ill;
    logic [6:0] op [2];
    logic [2:0] f3 [2];
    logic [6:0] f7 [2];
    logic [7:0] alu [2];
    logic [3:0] alu_a;
    logic [5:0] alu_b;

    assign alu[0] = {4'b0000, alu_a};
    assign alu[1] = {2'b00, alu_b};

    decode_ctrl #(.ALU_CTRL_W(4), .MUL_CYCLES(3), .EN_ITYPE(1)) dut_a (
        .clock(clock), .reset(rst[0]), .in_valid(iv[0]), .in_ready(ir[0]),
        .opcode(op[0]), .funct3(f3[0]), .funct7(f7[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .alu_control(alu_a),
        .regwrite_control(regw[0]), .alusrc_imm(asrc[0]), .illegal(ill[0]), .busy(bsy[0])
    );

    decode_ctrl #(.ALU_CTRL_W(6), .MUL_CYCLES(1), .EN_ITYPE(0)) dut_b (
        .clock(clock), .reset(rst[1]), .in_valid(iv[1]), .in_ready(ir[1]),
        .opcode(op[1]), .funct3(f3[1]), .funct7(f7[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .alu_control(alu_b),
        .regwrite_control(regw[1]), .alusrc_imm(asrc[1]), .illegal(ill[1]), .busy(bsy[1])
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        bit ill;
        bit regw;
        bit imm;
        int alu;
        bit mul;
    } dec_t;

    // Operation by funct3 when funct7 is zero; -1 marks "no operation".
    function automatic dec_t ref_decode(input logic [6:0] o, input logic [2:0] a,
                                        input logic [6:0] b, input bit en_it);
        int tbl [8] = '{2, 3, -1, -1, 7, 5, 1, 0};
        int code = -1;
        dec_t r;
        r.ill = 1; r.regw = 0; r.imm = 0; r.alu = 2; r.mul = 0;
        if (o == 7'b0110011) begin
            if (b == 7'd0)                     code = tbl[a];
            else if (b == 7'h20 && a == 3'd0)  code = 4;
            else if (b == 7'h01 && a == 3'd2)  begin code = 6; r.mul = 1; end
        end else if (o == 7'b0010011 && en_it) begin
            if (a == 3'd1 || a == 3'd5) code = (b == 7'd0) ? tbl[a] : -1;
            else                        code = tbl[a];
        end
        if (code >= 0) begin
            r.ill = 0; r.regw = 1; r.imm = (o == 7'b0010011); r.alu = code;
        end
        return r;
    endfunction

    task automatic run_dut(input int d, input bit en_it, input int mulc, input int ncyc);
        bit have_p = 0;
        bit after_rst = 1;
        int p_edge = 0;
        int p_lat = 1;
        int n;
        bit exp_ov, exp_busy, exp_ir;
        dec_t p_dec;
        string pfx = $sformatf("dut%0d", d);
        rst[d] = 1'b1; iv[d] = 1'b0; ordy[d] = 1'b0;
        op[d] = '0; f3[d] = '0; f7[d] = '0;
        @(negedge clock);
        @(negedge clock);
        for (int c = 0; c < ncyc; c++) begin
            rst[d]  = ($urandom_range(0, 63) == 0);
            iv[d]   = ($urandom_range(0, 3) != 0);
            ordy[d] = ($urandom_range(0, 2) != 0);
            f3[d]   = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0, 1:    op[d] = 7'b0110011;
                2:       op[d] = 7'b0010011;
                default: op[d] = 7'($urandom);
            endcase
            case ($urandom_range(0, 4))
                0, 1:    f7[d] = 7'd0;
                2:       f7[d] = 7'h20;
                3:       f7[d] = 7'h01;
                default: f7[d] = 7'($urandom);
            endcase
            if ($urandom_range(0, 5) == 0) begin
                op[d] = 7'b0110011; f3[d] = 3'd2; f7[d] = 7'h01;
            end
            #1;
            n = edges;
            exp_ov   = have_p && (n >= p_edge + p_lat - 1);
            exp_busy = have_p && !exp_ov;
            exp_ir   = !have_p || (exp_ov && ordy[d]);
            check_val({pfx, " out_valid"}, 32'(ov[d]), 32'(exp_ov));
            check_val({pfx, " busy"},      32'(bsy[d]), 32'(exp_busy));
            check_val({pfx, " in_ready"},  32'(ir[d]), 32'(exp_ir));
            if (after_rst) begin
                check_val({pfx, " rst alu"},  32'(alu[d]), 32'd0);
                check_val({pfx, " rst regw"}, 32'(regw[d]), 32'd0);
                check_val({pfx, " rst imm"},  32'(asrc[d]), 32'd0);
                check_val({pfx, " rst ill"},  32'(ill[d]), 32'd0);
            end else if (have_p) begin
                check_val({pfx, " alu"},  32'(alu[d]), 32'(p_dec.alu));
                check_val({pfx, " regw"}, 32'(regw[d]), 32'(p_dec.regw));
                check_val({pfx, " imm"},  32'(asrc[d]), 32'(p_dec.imm));
                check_val({pfx, " ill"},  32'(ill[d]), 32'(p_dec.ill));
            end
            after_rst = 0;
            if (rst[d]) begin
                have_p    = 0;
                after_rst = 1;
            end else begin
                if (exp_ov && ordy[d]) have_p = 0;
                if (iv[d] && exp_ir) begin
                    have_p = 1;
                    p_edge = n + 1;
                    p_dec  = ref_decode(op[d], f3[d], f7[d], en_it);
                    p_lat  = p_dec.mul ? mulc : 1;
                end
            end
            @(negedge clock);
        end
        rst[d] = 1'b0; iv[d] = 1'b0; ordy[d] = 1'b1;
    endtask

    initial begin
        fork
            run_dut(0, 1'b1, 3, 3000);
            run_dut(1, 1'b0, 1, 3000);
        join
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
